// File: rtl/sop_sweep_ctrl_pkg.sv
// Shared types and constants for the SoP sweep controller.
package sop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int VEC_W = 4;
  localparam int TT_W  = 16;
  localparam int CNT_W = 5;

  // a'cd' + bc + abd' -> minterms {2,6,7,12,14,15}
  localparam logic [TT_W-1:0] EXPECTED_SOP = 16'hD0C4;

endpackage

// File: rtl/sop_sweep_ctrl_if.sv
// Handshake and result bundle between the sweep controller and its user.
interface sop_sweep_ctrl_if;
  import sop_pkg::*;

  logic             start;
  logic             abort;
  logic             s_in;
  logic [VEC_W-1:0] vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [TT_W-1:0]  truth_table;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [VEC_W-1:0] first_fail;
  logic             fail_valid;

  modport slave (
    input  start, abort, s_in,
    output vec_out, busy, done, pass, truth_table, mismatch_cnt, first_fail, fail_valid
  );

  modport master (
    output start, abort, s_in,
    input  vec_out, busy, done, pass, truth_table, mismatch_cnt, first_fail, fail_valid
  );

endinterface

// File: rtl/sop_sweep_ctrl_vec_order.sv
// Step index -> stimulus vector mapping.
// SOP_SWEEP_GRAY_EN selects Gray-code order (one SoP input toggles per step);
// otherwise the step is presented directly in binary order.
module sop_vec_order
  import sop_pkg::*;
(
  input  logic [VEC_W-1:0] step,
  output logic [VEC_W-1:0] vec
);

`ifdef SOP_SWEEP_GRAY_EN
  assign vec = step ^ (step >> 1);
`else
  assign vec = step;
`endif

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Self-check sequencer for a 4-input SoP block: sweeps all 16 input vectors,
// captures the truth table and compares it against EXPECTED.
// Optional macro SOP_SWEEP_GRAY_EN (in sop_vec_order) selects Gray sweep order.
//
// state | meaning
// IDLE  | waiting for start, results held, vec_out = 0
// DRIVE | presenting vectors; each step SETTLE+1 cycles, s_in sampled on last
// DONE  | one-cycle done pulse, pass latched from final mismatch count
module sop_sweep_ctrl
  import sop_pkg::*;
#(
  parameter int              SETTLE   = 1,
  parameter logic [TT_W-1:0] EXPECTED = EXPECTED_SOP
) (
  input logic             clk,
  input logic             reset,
  sop_sweep_ctrl_if.slave bus
);

  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] step_q, step_d;
  logic [VEC_W-1:0] vec_q, vec_nxt;
  logic [SET_W-1:0] settle_q;
  logic [TT_W-1:0]  tt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VEC_W-1:0] ff_q;
  logic             fv_q;
  logic             pass_q;
  logic             sample_now;
  logic             last_step;
  logic             miss;

  assign sample_now = (state_q == DRIVE) && !bus.abort && (settle_q == '0);
  assign last_step  = (step_q == VEC_W'(TT_W - 1));
  assign miss       = (bus.s_in != EXPECTED[vec_q]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort wins over the final sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DRIVE;
      DRIVE: begin
        if (bus.abort)                    state_d = IDLE;
        else if (sample_now && last_step) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step index advances after each sample; the vector is mapped ahead so vec_out is registered.
  always_comb begin
    step_d = step_q;
    if (state_q == IDLE)               step_d = '0;
    else if (sample_now && !last_step) step_d = step_q + VEC_W'(1);
  end

  sop_vec_order u_order (
    .step (step_d),
    .vec  (vec_nxt)
  );

  // Sweep datapath: settle down-counter, capture, mismatch bookkeeping, pass latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      vec_q    <= '0;
      settle_q <= '0;
      tt_q     <= '0;
      cnt_q    <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      step_q <= step_d;
      vec_q  <= (state_d == DRIVE) ? vec_nxt : '0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            tt_q     <= '0;
            cnt_q    <= '0;
            ff_q     <= '0;
            fv_q     <= 1'b0;
            pass_q   <= 1'b0;
            settle_q <= SETTLE_LD;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            pass_q <= 1'b0;
          end else if (settle_q != '0) begin
            settle_q <= settle_q - SET_W'(1);
          end else begin
            tt_q[vec_q] <= bus.s_in;
            settle_q    <= SETTLE_LD;
            if (miss) begin
              if (cnt_q != CNT_W'(TT_W)) cnt_q <= cnt_q + CNT_W'(1);
              if (!fv_q) begin
                ff_q <= vec_q;
                fv_q <= 1'b1;
              end
            end
          end
        end
        DONE:    pass_q <= (cnt_q == '0);
        default: ;
      endcase
    end
  end

  assign bus.vec_out      = vec_q;
  assign bus.busy         = (state_q == DRIVE);
  assign bus.done         = (state_q == DONE);
  assign bus.pass         = pass_q;
  assign bus.truth_table  = tt_q;
  assign bus.mismatch_cnt = cnt_q;
  assign bus.first_fail   = ff_q;
  assign bus.fail_valid   = fv_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Directed bench for sop_sweep_ctrl (SETTLE=1, default EXPECTED).
// Works for both the binary and SOP_SWEEP_GRAY_EN builds.
module tb_sop_sweep_ctrl;
  import sop_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;  // 0: correct SoP, 1: s tied 0, 2: s tied 1

  sop_sweep_ctrl_if bus();

  sop_sweep_ctrl #(.SETTLE(1), .EXPECTED(16'hD0C4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic sop_ref(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (~a & c & ~d) | (b & c) | (a & b & ~d);
  endfunction

  function automatic logic [3:0] exp_order(input logic [3:0] s);
`ifdef SOP_SWEEP_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  always_comb begin
    bus.s_in = 1'b0;
    if (mode == 0)      bus.s_in = sop_ref(bus.vec_out);
    else if (mode == 2) bus.s_in = 1'b1;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    cyc; cyc;
    total++;
    if ({bus.vec_out, bus.busy, bus.done, bus.pass, bus.truth_table,
         bus.mismatch_cnt, bus.first_fail, bus.fail_valid} !== '0)
      begin bad++; $display("FAIL reset_outputs: vec=%0d busy=%b done=%b pass=%b tt=%h cnt=%0d ff=%0d fv=%b, want all 0",
        bus.vec_out, bus.busy, bus.done, bus.pass, bus.truth_table, bus.mismatch_cnt, bus.first_fail, bus.fail_valid); end
    reset = 1'b0;
    cyc;
  endtask

  task automatic test_sweep(input string nm, input int m, input logic [15:0] e_tt,
                            input logic [4:0] e_cnt, input logic [3:0] e_ff,
                            input logic e_fv, input logic e_pass);
    mode = m;
    bus.start = 1'b1; cyc; bus.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      total++;
      if (bus.vec_out !== exp_order(4'(k / 2)) || bus.busy !== 1'b1 || bus.done !== 1'b0)
        begin bad++; $display("FAIL %s_drive cyc%0d: vec=%0d busy=%b done=%b, want vec=%0d busy=1 done=0",
          nm, k, bus.vec_out, bus.busy, bus.done, exp_order(4'(k / 2))); end
      cyc;
    end
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      begin bad++; $display("FAIL %s_done_pulse: done=%b busy=%b, want 1 0", nm, bus.done, bus.busy); end
    total++;
    if (bus.truth_table !== e_tt)
      begin bad++; $display("FAIL %s_tt: got %h want %h", nm, bus.truth_table, e_tt); end
    total++;
    if (bus.mismatch_cnt !== e_cnt)
      begin bad++; $display("FAIL %s_cnt: got %0d want %0d", nm, bus.mismatch_cnt, e_cnt); end
    total++;
    if (bus.fail_valid !== e_fv || bus.first_fail !== e_ff)
      begin bad++; $display("FAIL %s_first_fail: got fv=%b ff=%0d want fv=%b ff=%0d",
        nm, bus.fail_valid, bus.first_fail, e_fv, e_ff); end
    bus.start = 1'b1; cyc; bus.start = 1'b0;  // start during DONE must be ignored
    total++;
    if (bus.pass !== e_pass)
      begin bad++; $display("FAIL %s_pass: got %b want %b", nm, bus.pass, e_pass); end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_out !== 4'd0)
      begin bad++; $display("FAIL %s_idle_after: busy=%b done=%b vec=%0d, want 0 0 0",
        nm, bus.busy, bus.done, bus.vec_out); end
  endtask

  task automatic test_abort;
    logic [15:0] mask;
    bit          saw_done;
    mask = '0; saw_done = 0; mode = 0;
    bus.start = 1'b1; cyc; bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.vec_out !== 4'd5; i++) begin
      mask[bus.vec_out] = 1'b1;
      bus.start = (i == 3);
      cyc;
    end
    bus.start = 1'b0;
    total++;
    if (bus.vec_out !== 4'd5 || bus.busy !== 1'b1)
      begin bad++; $display("FAIL abort_reach5: vec=%0d busy=%b, want 5 1", bus.vec_out, bus.busy); end
    bus.abort = 1'b1; cyc; bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.vec_out !== 4'd0 || bus.done !== 1'b0)
      begin bad++; $display("FAIL abort_idle: busy=%b vec=%0d done=%b, want 0 0 0", bus.busy, bus.vec_out, bus.done); end
    total++;
    if (bus.truth_table !== (16'hD0C4 & mask) || bus.mismatch_cnt !== 5'd0 || bus.fail_valid !== 1'b0)
      begin bad++; $display("FAIL abort_partial: tt=%h cnt=%0d fv=%b, want tt=%h cnt=0 fv=0",
        bus.truth_table, bus.mismatch_cnt, bus.fail_valid, 16'hD0C4 & mask); end
    for (int i = 0; i < 4; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1;
      cyc;
    end
    total++;
    if (saw_done || bus.pass !== 1'b0)
      begin bad++; $display("FAIL abort_no_done: saw_activity=%0d pass=%b, want 0 0", saw_done, bus.pass); end
  endtask

  task automatic test_reset_mid;
    mode = 0;
    bus.start = 1'b1; cyc; bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.vec_out !== 4'd9; i++) cyc;
    total++;
    if (bus.vec_out !== 4'd9)
      begin bad++; $display("FAIL reset_mid_reach9: vec=%0d want 9", bus.vec_out); end
    reset = 1'b1; cyc; reset = 1'b0;
    total++;
    if ({bus.vec_out, bus.busy, bus.done, bus.pass, bus.truth_table,
         bus.mismatch_cnt, bus.first_fail, bus.fail_valid} !== '0)
      begin bad++; $display("FAIL reset_mid_outputs: vec=%0d busy=%b tt=%h cnt=%0d fv=%b, want all 0",
        bus.vec_out, bus.busy, bus.truth_table, bus.mismatch_cnt, bus.fail_valid); end
    cyc;
    test_sweep("after_reset", 0, 16'hD0C4, 5'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_start_abort_idle;
    bus.start = 1'b1; bus.abort = 1'b1; cyc;
    bus.start = 1'b0; bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.vec_out !== exp_order(4'd0) || bus.truth_table !== 16'h0000)
      begin bad++; $display("FAIL start_abort_idle: busy=%b vec=%0d tt=%h, want busy=1 vec=0 tt=0000",
        bus.busy, bus.vec_out, bus.truth_table); end
    bus.abort = 1'b1; cyc; bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0)
      begin bad++; $display("FAIL start_abort_cleanup: busy=%b want 0", bus.busy); end
  endtask

  initial begin
    test_reset;
    test_sweep("correct", 0, 16'hD0C4, 5'd0,  4'd0, 1'b0, 1'b1);
    test_sweep("tie0",    1, 16'h0000, 5'd6,  4'd2, 1'b1, 1'b0);
    test_sweep("tie1",    2, 16'hFFFF, 5'd10, 4'd0, 1'b1, 1'b0);
    test_sweep("rerun",   0, 16'hD0C4, 5'd0,  4'd0, 1'b0, 1'b1);
    test_abort;
    test_reset_mid;
    test_start_abort_idle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
